id_stage_pipe: RTL and testbench



---
 rtl/id_stage_pipe_pkg.sv | 21 ++
 rtl/id_regfile.sv | 43 ++++
 rtl/id_stage_pipe.sv | 185 ++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - MIPS opcode and funct constants shared by the ID stage
package id_stage_pipe_pkg;

    typedef enum logic [5:0] {
        R_FORM = 6'h00,
        J      = 6'h02,
        JAL    = 6'h03,
        BEQ    = 6'h04,
        BNE    = 6'h05,
        ADDI   = 6'h08,
        ANDI   = 6'h0C,
        ORI    = 6'h0D,
        XORI   = 6'h0E,
        LUI    = 6'h0F,
        LW     = 6'h23,
        SW     = 6'h2B
    } opcode_e;

    localparam logic [5:0] JR = 6'h08;

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - 2R1W register file with hardwired zero entry and write-back bypass
module id_regfile #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    localparam int AW     = $clog2(REG_NUM)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            wen_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [REG_NUM];
    logic            wr;

    assign wr = wen_i && (waddr_i != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle write-back is forwarded so WB and ID can share a cycle.
    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        rdata2_o = mem_q[raddr2_i];
        if (raddr1_i == '0)                rdata1_o = '0;
        else if (wr && waddr_i == raddr1_i) rdata1_o = wdata_i;
        if (raddr2_i == '0)                rdata2_o = '0;
        else if (wr && waddr_i == raddr2_i) rdata2_o = wdata_i;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - pipelined decode stage with ID/EX register; ID_STALL_CNT_EN adds a bubble counter output
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int LINK_REG = 31,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Ins,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      ex_op,
    output logic [5:0]      ex_funct,
    output logic [4:0]      ex_shamt,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_waddr,
    output logic            ex_wen,
    output logic            ex_mem_read
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    logic [5:0]      op, funct;
    logic [4:0]      shamt;
    logic [AW-1:0]   rs, rt, rd;
    logic [XLEN-1:0] rdata1, rdata2;
    logic [XLEN-1:0] dec_imm;
    logic [AW-1:0]   dec_waddr;
    logic            dec_wen, uses_rt;
    logic            hazard, accept, bubble;

    logic            out_valid_q, out_valid_d;
    logic [5:0]      op_q, op_d, funct_q, funct_d;
    logic [4:0]      shamt_q, shamt_d;
    logic [XLEN-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic            wen_q, wen_d, mem_read_q, mem_read_d;

    assign op    = Ins[31:26];
    assign rs    = AW'(Ins[25:21]);
    assign rt    = AW'(Ins[20:16]);
    assign rd    = AW'(Ins[15:11]);
    assign shamt = Ins[10:6];
    assign funct = Ins[5:0];

    id_regfile #(.XLEN(XLEN), .REG_NUM(REG_NUM)) u_regfile (
        .CLK      (CLK),
        .RST      (RST),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2),
        .wen_i    (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    always_comb begin
        dec_imm   = XLEN'($signed(Ins[15:0]));
        dec_waddr = rt;
        dec_wen   = 1'b1;
        uses_rt   = 1'b0;
        case (op)
            ANDI, ORI, XORI: dec_imm = XLEN'(Ins[15:0]);
            LUI:             dec_imm = XLEN'($signed({Ins[15:0], 16'h0000}));
            default:         ;
        endcase
        case (op)
            R_FORM: begin
                dec_waddr = rd;
                dec_wen   = (funct != JR);
                uses_rt   = 1'b1;
            end
            JAL:          dec_waddr = AW'(LINK_REG);
            SW:           begin dec_wen = 1'b0; uses_rt = 1'b1; end
            BEQ, BNE:     begin dec_wen = 1'b0; uses_rt = 1'b1; end
            J:            dec_wen = 1'b0;
            default:      ;
        endcase
    end

    // A load in EX cannot forward in time for a consumer in ID.
    assign hazard   = out_valid_q && mem_read_q && (waddr_q != '0) &&
                      ((waddr_q == rs) || (uses_rt && (waddr_q == rt)));
    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign bubble   = !flush && !accept && hazard && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        op_d        = op_q;
        funct_d     = funct_q;
        shamt_d     = shamt_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        imm_d       = imm_q;
        waddr_d     = waddr_q;
        wen_d       = wen_q;
        mem_read_d  = mem_read_q;
        if (flush) begin
            out_valid_d = 1'b0;
            wen_d       = 1'b0;
            mem_read_d  = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            op_d        = op;
            funct_d     = funct;
            shamt_d     = shamt;
            rdata1_d    = rdata1;
            rdata2_d    = rdata2;
            imm_d       = dec_imm;
            waddr_d     = dec_waddr;
            wen_d       = dec_wen;
            mem_read_d  = (op == LW);
        end else if (bubble) begin
            out_valid_d = 1'b0;
            wen_d       = 1'b0;
            mem_read_d  = 1'b0;
        end else if (out_ready && !in_valid) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            op_q        <= '0;
            funct_q     <= '0;
            shamt_q     <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            imm_q       <= '0;
            waddr_q     <= '0;
            wen_q       <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            funct_q     <= funct_d;
            shamt_q     <= shamt_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            imm_q       <= imm_d;
            waddr_q     <= waddr_d;
            wen_q       <= wen_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign ex_op       = op_q;
    assign ex_funct    = funct_q;
    assign ex_shamt    = shamt_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign ex_waddr    = waddr_q;
    assign ex_wen      = wen_q;
    assign ex_mem_read = mem_read_q;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         stall_cnt_q <= '0;
        else if (bubble) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0] Ins, wb_data;
    logic [4:0]  wb_addr;
    logic [5:0]  ex_op, ex_funct;
    logic [4:0]  ex_shamt, ex_waddr;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm;
    logic        ex_wen, ex_mem_read;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 CLK = ~CLK;

    id_stage_pipe dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .Ins(Ins),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .ex_op(ex_op), .ex_funct(ex_funct),
        .ex_shamt(ex_shamt), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_waddr(ex_waddr), .ex_wen(ex_wen), .ex_mem_read(ex_mem_read)
`ifdef ID_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [119:0] dut_b;
    assign dut_b = {ex_op, ex_funct, ex_shamt, ex_rdata1, ex_rdata2, ex_imm, ex_waddr, ex_wen, ex_mem_read};

    // Reference model: architectural register array plus the ID/EX contents.
    logic [31:0] rf [32];
    logic        m_valid, m_wen, m_mr;
    logic [5:0]  m_op, m_funct;
    logic [4:0]  m_shamt, m_waddr;
    logic [31:0] m_rd1, m_rd2, m_imm;
    int unsigned m_stall;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [119:0] m_bundle();
        return {m_op, m_funct, m_shamt, m_rd1, m_rd2, m_imm, m_waddr, m_wen, m_mr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        m_valid = 0; m_wen = 0; m_mr = 0; m_op = 0; m_funct = 0; m_shamt = 0;
        m_waddr = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_stall = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return rf[a];
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] ins);
        case (ins[31:26])
            6'h0C, 6'h0D, 6'h0E: return {16'h0, ins[15:0]};
            6'h0F:               return {ins[15:0], 16'h0};
            default:             return {{16{ins[15]}}, ins[15:0]};
        endcase
    endfunction

    function automatic logic m_hazard();
        logic [5:0] op;
        logic       rt_used;
        op = Ins[31:26];
        rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        return m_valid && m_mr && m_waddr != 0 &&
               (m_waddr == Ins[25:21] || (rt_used && m_waddr == Ins[20:16]));
    endfunction

    function automatic logic m_ready();
        return (!m_valid || out_ready) && !m_hazard();
    endfunction

    task automatic model_update();
        logic [5:0] op;
        logic       haz, acc;
        op  = Ins[31:26];
        haz = m_hazard();
        acc = in_valid && m_ready();
        if (flush) begin
            m_valid = 0; m_wen = 0; m_mr = 0;
        end else if (acc) begin
            m_valid = 1;
            m_op = op; m_funct = Ins[5:0]; m_shamt = Ins[10:6];
            m_rd1 = m_read(Ins[25:21]); m_rd2 = m_read(Ins[20:16]);
            m_imm = m_ext(Ins);
            m_waddr = (op == 6'h03) ? 5'd31 : (op == 6'h00) ? Ins[15:11] : Ins[20:16];
            m_wen = !(op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02 ||
                      (op == 6'h00 && Ins[5:0] == 6'h08));
            m_mr = (op == 6'h23);
        end else if (haz && out_ready) begin
            m_valid = 0; m_wen = 0; m_mr = 0;
            m_stall++;
        end else if (out_ready && !in_valid) begin
            m_valid = 0;
        end
        if (wb_en && wb_addr != 0) rf[wb_addr] = wb_data;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        #1;
        chk("in_ready", {127'h0, in_ready}, {127'h0, m_ready()});
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        chk("out_valid", {127'h0, out_valid}, {127'h0, m_valid});
        chk("ex_fields", {8'h0, dut_b}, {8'h0, m_bundle()});
`ifdef ID_STALL_CNT_EN
        chk("stall_cnt", {96'h0, stall_cnt}, {96'h0, m_stall});
`endif
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] imm;
        logic [4:0]  waddr;
        logic        wen;
        logic        mr;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [31:0] rand_ins();
        logic [5:0] ops [12];
        logic [5:0] fns [3];
        logic [5:0] op;
        logic [15:0] lo;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        fns = '{6'h20, 6'h08, 6'h22};
        op = ops[$urandom_range(0, 11)];
        lo = 16'($urandom);
        if (op == 6'h00)
            lo = {3'b000, 2'($urandom_range(0, 3)), 5'($urandom), fns[$urandom_range(0, 2)]};
        return {op, 3'b000, 2'($urandom_range(0, 3)), 3'b000, 2'($urandom_range(0, 3)), lo};
    endfunction

    initial begin
        tbl[0]  = '{32'h34098000, 0, 5'd0, 32'h0,        32'h00008000, 5'd9,  1, 0, 32'h0, 32'h0};
        tbl[1]  = '{32'h2009FFFF, 0, 5'd0, 32'h0,        32'hFFFFFFFF, 5'd9,  1, 0, 32'h0, 32'h0};
        tbl[2]  = '{32'h3C091234, 0, 5'd0, 32'h0,        32'h12340000, 5'd9,  1, 0, 32'h0, 32'h0};
        tbl[3]  = '{32'h01095020, 1, 5'd9, 32'hDEADBEEF, 32'h00005020, 5'd10, 1, 0, 32'h0, 32'hDEADBEEF};
        tbl[4]  = '{32'h00095020, 1, 5'd0, 32'h12345678, 32'h00005020, 5'd10, 1, 0, 32'h0, 32'hDEADBEEF};
        tbl[5]  = '{32'h0C000010, 0, 5'd0, 32'h0,        32'h00000010, 5'd31, 1, 0, 32'h0, 32'h0};
        tbl[6]  = '{32'hAE280004, 0, 5'd0, 32'h0,        32'h00000004, 5'd8,  0, 0, 32'h0, 32'h0};
        tbl[7]  = '{32'h03E00008, 0, 5'd0, 32'h0,        32'h00000008, 5'd0,  0, 0, 32'h0, 32'h0};
        tbl[8]  = '{32'h1109FFFE, 0, 5'd0, 32'h0,        32'hFFFFFFFE, 5'd9,  0, 0, 32'h0, 32'hDEADBEEF};
        tbl[9]  = '{32'h8E280000, 0, 5'd0, 32'h0,        32'h00000000, 5'd8,  1, 1, 32'h0, 32'h0};
        tbl[10] = '{32'h3843FFFF, 0, 5'd0, 32'h0,        32'h0000FFFF, 5'd3,  1, 0, 32'h0, 32'h0};

        RST = 1; in_valid = 0; out_ready = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; Ins = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("reset out_valid", {127'h0, out_valid}, 128'h0);
        chk("reset ex_fields", {8'h0, dut_b}, 128'h0);
        RST = 0;

        for (int i = 0; i < 11; i++) begin
            Ins = tbl[i].ins; in_valid = 1; out_ready = 1; flush = 0;
            wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
            step();
            chk($sformatf("vec%0d valid", i), {127'h0, out_valid}, 128'h1);
            chk($sformatf("vec%0d imm", i), {96'h0, ex_imm}, {96'h0, tbl[i].imm});
            chk($sformatf("vec%0d waddr", i), {123'h0, ex_waddr}, {123'h0, tbl[i].waddr});
            chk($sformatf("vec%0d wen/mr", i), {126'h0, ex_wen, ex_mem_read}, {126'h0, tbl[i].wen, tbl[i].mr});
            chk($sformatf("vec%0d rdata1", i), {96'h0, ex_rdata1}, {96'h0, tbl[i].rd1});
            chk($sformatf("vec%0d rdata2", i), {96'h0, ex_rdata2}, {96'h0, tbl[i].rd2});
        end
        wb_en = 0;

        // Load-use: LW $t0 then ADD $t2,$t0,$t1 -> one bubble, then ADD with bypassed load data.
        Ins = 32'h8E280000; step();
        Ins = 32'h01095020;
        #1 chk("lduse in_ready", {127'h0, in_ready}, 128'h0);
        step();
        chk("lduse bubble", {127'h0, out_valid}, 128'h0);
        wb_en = 1; wb_addr = 5'd8; wb_data = 32'hCAFEF00D;
        step();
        wb_en = 0;
        chk("lduse accept", {127'h0, out_valid}, 128'h1);
        chk("lduse rdata1", {96'h0, ex_rdata1}, {96'h0, 32'hCAFEF00D});
        chk("lduse rdata2", {96'h0, ex_rdata2}, {96'h0, 32'hDEADBEEF});
`ifdef ID_STALL_CNT_EN
        chk("lduse stall_cnt", {96'h0, stall_cnt}, 128'h1);
`endif

        // Back-pressure holds, then flush drops the incoming ORI.
        out_ready = 0; in_valid = 1; Ins = 32'h34098000;
        step(); step();
        chk("hold valid", {127'h0, out_valid}, 128'h1);
        chk("hold rdata1", {96'h0, ex_rdata1}, {96'h0, 32'hCAFEF00D});
        flush = 1;
        step();
        flush = 0;
        chk("flush valid", {127'h0, out_valid}, 128'h0);
        out_ready = 1; in_valid = 0;
        step();
        chk("flush dropped valid", {127'h0, out_valid}, 128'h0);
        chk("flush dropped imm", {96'h0, ex_imm}, {96'h0, 32'h00005020});

        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            Ins       = rand_ins();
            step();
        end

        // Reset while a load-use stall is pending.
        flush = 1; in_valid = 0; out_ready = 1; wb_en = 1; wb_addr = 5'd9; wb_data = 32'h55AA55AA;
        step();
        flush = 0; wb_en = 0; in_valid = 1; Ins = 32'h8E280000;
        step();
        Ins = 32'h01095020;
        #1 chk("rst stall in_ready", {127'h0, in_ready}, 128'h0);
        RST = 1;
        #1;
        chk("rst async valid", {127'h0, out_valid}, 128'h0);
        chk("rst async fields", {8'h0, dut_b}, 128'h0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 0;
        step();
        chk("rst after valid", {127'h0, out_valid}, 128'h1);
        chk("rst regfile cleared", {96'h0, ex_rdata2}, 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
